commit_perf_monitor: RTL and testbench

Performance and termination monitor that sits directly downstream of the reorder buffer's commit port inside the out-of-order CPU top level. It consumes per-cycle retirement information and produces the `cycles_consumed` count the simulation top reports. It also produces retired-instruction, mispredict and stall statistics. It freezes all counts when a halt instruction retires or when a commit watchdog expires, giving the bench a deterministic end-of-program signature.

---
 rtl/commit_perf_monitor_if.sv | 29 ++
 rtl/commit_perf_monitor.sv | 94 +++++++++
 tb/tb_commit_perf_monitor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/commit_perf_monitor_if.sv
// Commit-port bundle between the ROB retire stage and the performance monitor.
// Carries the per-cycle retire flags and the monitor's statistics back out.
// master = retire side (drives commit flags), slave = monitor side.
interface commit_perf_monitor_if #(
    parameter int CNT_W = 32
);
    logic             commit_valid;
    logic             commit_is_halt;
    logic             commit_mispredict;
    logic             rob_full;
    logic [CNT_W-1:0] cycles_consumed;
    logic [CNT_W-1:0] insts_committed;
    logic [CNT_W-1:0] mispredicts;
    logic [CNT_W-1:0] stall_cycles;
    logic             halted;
    logic             timeout;

    modport master (
        output commit_valid, commit_is_halt, commit_mispredict, rob_full,
        input  cycles_consumed, insts_committed, mispredicts, stall_cycles,
        input  halted, timeout
    );

    modport slave (
        input  commit_valid, commit_is_halt, commit_mispredict, rob_full,
        output cycles_consumed, insts_committed, mispredicts, stall_cycles,
        output halted, timeout
    );
endinterface

// File: rtl/commit_perf_monitor.sv
// Retire-side performance monitor: counts cycles/commits/mispredicts/stalls until halt or watchdog.
// Latency: one edge; a commit sampled at edge N shows in the counters after edge N.
// No backpressure: every retire pulse is consumed; terminal states ignore all inputs.
module commit_perf_monitor #(
    parameter int CNT_W    = 32,
    parameter int WD_LIMIT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    commit_perf_monitor_if.slave   mon
);
    // One-hot-ish encoding so halted/timeout come straight off state flops.
    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [15:0]      IDLE_MAX = 16'hFFFF;
    localparam logic [15:0]      WD_LAST  = 16'(WD_LIMIT - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] inst_q;
    logic [CNT_W-1:0] misp_q;
    logic [CNT_W-1:0] stall_q;
    logic [15:0]      idle_q;
    logic             in_run;
    logic             commit;

    assign in_run = (state == ST_RUN);
    assign commit = mon.commit_valid;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
    endfunction

    // Next state: halt has priority over the watchdog; terminal states are sticky.
    always_comb begin
        state_nxt = state;
        if (state == ST_RUN) begin
            if (commit && mon.commit_is_halt) begin
                state_nxt = ST_HALTED;
            end else if (!commit && (idle_q == WD_LAST)) begin
                state_nxt = ST_TIMEOUT;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Statistics counters update only in RUN, including the edge that leaves RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q   <= '0;
            inst_q  <= '0;
            misp_q  <= '0;
            stall_q <= '0;
        end else if (in_run) begin
            cyc_q   <= sat_inc(cyc_q, 1'b1);
            inst_q  <= sat_inc(inst_q, commit);
            misp_q  <= sat_inc(misp_q, commit & mon.commit_mispredict);
            stall_q <= sat_inc(stall_q, mon.rob_full);
        end
    end

    // Idle counter: run length of consecutive no-commit RUN cycles, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
        end else if (in_run) begin
            if (commit) begin
                idle_q <= '0;
            end else if (idle_q != IDLE_MAX) begin
                idle_q <= idle_q + 16'd1;
            end
        end
    end

    assign mon.cycles_consumed = cyc_q;
    assign mon.insts_committed = inst_q;
    assign mon.mispredicts     = misp_q;
    assign mon.stall_cycles    = stall_q;
    assign mon.halted          = state[0];
    assign mon.timeout         = state[1];
endmodule

// File: tb/tb_commit_perf_monitor.sv
// Bench for commit_perf_monitor: three instances (default, WD_LIMIT=4, CNT_W=4/WD_LIMIT=100)
// share one directed stimulus stream; a per-instance behavioural model is compared every
// negedge, and literal expectations from hand calculation pin the model at key points.
module tb_commit_perf_monitor;
    logic clk;
    logic rst;
    logic valid, halt, misp, full;
    logic chk_en;
    int   total;
    int   bad;

    commit_perf_monitor_if #(.CNT_W(32)) if_a ();
    commit_perf_monitor_if #(.CNT_W(32)) if_b ();
    commit_perf_monitor_if #(.CNT_W(4))  if_c ();

    assign if_a.commit_valid = valid;  assign if_a.commit_is_halt = halt;
    assign if_a.commit_mispredict = misp;  assign if_a.rob_full = full;
    assign if_b.commit_valid = valid;  assign if_b.commit_is_halt = halt;
    assign if_b.commit_mispredict = misp;  assign if_b.rob_full = full;
    assign if_c.commit_valid = valid;  assign if_c.commit_is_halt = halt;
    assign if_c.commit_mispredict = misp;  assign if_c.rob_full = full;

    commit_perf_monitor #(.CNT_W(32), .WD_LIMIT(1000)) dut_a (.clk(clk), .rst(rst), .mon(if_a.slave));
    commit_perf_monitor #(.CNT_W(32), .WD_LIMIT(4))    dut_b (.clk(clk), .rst(rst), .mon(if_b.slave));
    commit_perf_monitor #(.CNT_W(4),  .WD_LIMIT(100))  dut_c (.clk(clk), .rst(rst), .mon(if_c.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    localparam logic [63:0] CMAX [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};
    localparam int          WD   [3] = '{1000, 4, 100};

    logic [63:0] m_cyc [3];
    logic [63:0] m_inst[3];
    logic [63:0] m_mis [3];
    logic [63:0] m_stl [3];
    int          m_run [3];
    logic        m_hlt [3];
    logic        m_to  [3];

    function automatic logic [63:0] bump(input logic [63:0] x, input logic [63:0] mx, input logic en);
        return (en && (x < mx)) ? x + 64'd1 : x;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_cyc[i] = 0; m_inst[i] = 0; m_mis[i] = 0; m_stl[i] = 0;
            m_run[i] = 0; m_hlt[i] = 1'b0; m_to[i] = 1'b0;
        end
    endtask

    initial model_clear();

    always @(negedge rst) model_clear();

    always @(posedge clk) begin
        if (!rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_hlt[i] && !m_to[i]) begin
                    m_cyc[i]  = bump(m_cyc[i], CMAX[i], 1'b1);
                    m_inst[i] = bump(m_inst[i], CMAX[i], valid);
                    m_mis[i]  = bump(m_mis[i], CMAX[i], valid & misp);
                    m_stl[i]  = bump(m_stl[i], CMAX[i], full);
                    m_run[i]  = valid ? 0 : m_run[i] + 1;
                    if (valid && halt) m_hlt[i] = 1'b1;
                    else if (m_run[i] == WD[i]) m_to[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle model comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a_cyc",  64'(if_a.cycles_consumed), m_cyc[0]);
            cmp("a_inst", 64'(if_a.insts_committed), m_inst[0]);
            cmp("a_mis",  64'(if_a.mispredicts),     m_mis[0]);
            cmp("a_stl",  64'(if_a.stall_cycles),    m_stl[0]);
            cmp("a_hlt",  64'(if_a.halted),          64'(m_hlt[0]));
            cmp("a_to",   64'(if_a.timeout),         64'(m_to[0]));
            cmp("b_cyc",  64'(if_b.cycles_consumed), m_cyc[1]);
            cmp("b_inst", 64'(if_b.insts_committed), m_inst[1]);
            cmp("b_mis",  64'(if_b.mispredicts),     m_mis[1]);
            cmp("b_stl",  64'(if_b.stall_cycles),    m_stl[1]);
            cmp("b_hlt",  64'(if_b.halted),          64'(m_hlt[1]));
            cmp("b_to",   64'(if_b.timeout),         64'(m_to[1]));
            cmp("c_cyc",  64'(if_c.cycles_consumed), m_cyc[2]);
            cmp("c_inst", 64'(if_c.insts_committed), m_inst[2]);
            cmp("c_mis",  64'(if_c.mispredicts),     m_mis[2]);
            cmp("c_stl",  64'(if_c.stall_cycles),    m_stl[2]);
            cmp("c_hlt",  64'(if_c.halted),          64'(m_hlt[2]));
            cmp("c_to",   64'(if_c.timeout),         64'(m_to[2]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic h, input logic m, input logic f);
        valid = v; halt = h; misp = m; full = f;
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand();
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        rst = 1'b0;
        valid = 1'b0; halt = 1'b0; misp = 1'b0; full = 1'b0;

        // Reset held for 2 cycles with random inputs
        step_rand();
        chk_en = 1'b1;
        step_rand();
        cmp("rst_cyc",  64'(if_a.cycles_consumed), 64'd0);
        cmp("rst_inst", 64'(if_a.insts_committed), 64'd0);
        cmp("rst_stl",  64'(if_a.stall_cycles),    64'd0);
        cmp("rst_hlt",  64'(if_a.halted),          64'd0);
        cmp("rst_to",   64'(if_a.timeout),         64'd0);
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("idle3_cyc",  64'(if_a.cycles_consumed), 64'd3);
        cmp("idle3_inst", 64'(if_a.insts_committed), 64'd0);
        cmp("idle3_bto",  64'(if_b.timeout),         64'd0);

        // Qualification: halt/mispredict without valid are ignored
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
        cmp("qual_cyc",  64'(if_a.cycles_consumed), 64'd6);
        cmp("qual_mis",  64'(if_a.mispredicts),     64'd0);
        cmp("qual_inst", 64'(if_a.insts_committed), 64'd0);
        cmp("qual_hlt",  64'(if_a.halted),          64'd0);
        // WD_LIMIT=4 instance saw 6 idle edges: timed out at edge 4
        cmp("wd_to",  64'(if_b.timeout),         64'd1);
        cmp("wd_cyc", 64'(if_b.cycles_consumed), 64'd4);

        // Normal program
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cmp("prog_cyc",  64'(if_a.cycles_consumed), 64'd6);
            cmp("prog_inst", 64'(if_a.insts_committed), 64'd6);
            cmp("prog_mis",  64'(if_a.mispredicts),     64'd1);
            cmp("prog_stl",  64'(if_a.stall_cycles),    64'd2);
            cmp("prog_hlt",  64'(if_a.halted),          64'd1);
            cmp("prog_to",   64'(if_a.timeout),         64'd0);
            repeat (10) step_rand();
        end

        // Watchdog second run: commit on edge 3, timeout after edge 7
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("wd2_to6", 64'(if_b.timeout), 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("wd2_to7",  64'(if_b.timeout),         64'd1);
        cmp("wd2_cyc",  64'(if_b.cycles_consumed), 64'd7);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("wd2_hold", 64'(if_b.cycles_consumed), 64'd7);

        // Mid-run reset pulse between edges
        do_reset();
        repeat (7) step(1'b0, 1'b0, 1'b1, 1'b1);
        cmp("mid_pre", 64'(if_a.cycles_consumed), 64'd7);
        #1 rst = 1'b0;
        #1;
        cmp("mid_cyc",  64'(if_a.cycles_consumed), 64'd0);
        cmp("mid_stl",  64'(if_a.stall_cycles),    64'd0);
        cmp("mid_bto",  64'(if_b.timeout),         64'd0);
        #1 rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        cmp("mid_hcyc", 64'(if_a.cycles_consumed), 64'd2);
        cmp("mid_hlt",  64'(if_a.halted),          64'd1);
        cmp("mid_inst", 64'(if_a.insts_committed), 64'd1);

        // Saturation on the 4-bit instance
        do_reset();
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("sat_cyc", 64'(if_c.cycles_consumed), 64'd15);
        cmp("sat_stl", 64'(if_c.stall_cycles),    64'd15);
        cmp("sat_to",  64'(if_c.timeout),         64'd0);
        cmp("sat_acyc", 64'(if_a.cycles_consumed), 64'd20);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("sat_hold", 64'(if_c.cycles_consumed), 64'd15);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
